// File: rtl/pattern_feed_pkg.sv
// Shared types and constants for the pattern feed controller.
//   state_e   : controller FSM states (IDLE, SHIFT, DRAIN, DONE)
//   DRAIN_CYC : cycles spent after the last step so the detector's registered
//               output can still be observed
package pattern_feed_pkg;

    localparam int DRAIN_CYC = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/pattern_feed_ctrl_if.sv
// Handshake and detector bus of the pattern feed controller.
//   start, word          : run request and stimulus word (master -> controller)
//   det_out              : registered match output of the detector (master -> controller)
//   det_rst, det_en,
//   det_in               : detector reset, step enable and serial stimulus bit
//   busy, done           : run in progress / one-cycle completion pulse
//   hit_count, hit_valid,
//   first_hit            : results of the last run
interface pattern_feed_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] word;
    logic             det_out;
    logic             det_rst;
    logic             det_en;
    logic             det_in;
    logic             busy;
    logic             done;
    logic [3:0]       hit_count;
    logic             hit_valid;
    logic [3:0]       first_hit;

    modport master (
        output start, word, det_out,
        input  det_rst, det_en, det_in, busy, done, hit_count, hit_valid, first_hit
    );

    modport slave (
        input  start, word, det_out,
        output det_rst, det_en, det_in, busy, done, hit_count, hit_valid, first_hit
    );
endinterface

// File: rtl/pattern_feed_ctrl_tick_gen.sv
// Step divider: produces a registered one-cycle tick every DIV cycles of run.
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart the count (the next tick follows DIV run cycles later)
//   run        : count enable
//   tick       : high for one cycle when the count sits at DIV-1
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);
    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // tick is decoded from the next count so that the registered tick lines
    // up with the cycle in which the count equals DIV-1.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d  = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);
            tick_d = (cnt_d == CW'(DIV - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
endmodule

// File: rtl/pattern_feed_ctrl.sv
// Pattern feed controller: on start, resets a downstream sequence detector,
// feeds it the latched word MSB first (one bit per DIV cycles), then counts
// rising edges of the detector's match output and reports the results.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of pattern_feed_ctrl_if (start/word/det_out in,
//                detector controls, status and results out; all registered)
module pattern_feed_ctrl #(
    parameter int WIDTH = 16,
    parameter int DIV   = 4
) (
    input  logic               clk,
    input  logic               reset,
    pattern_feed_ctrl_if.slave bus
);
    import pattern_feed_pkg::*;

    localparam int IW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [1:0]       drain_q, drain_d;
    logic             prev_q, prev_d;
    logic             det_rst_q, det_rst_d;
    logic             det_in_q, det_in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [3:0]       hit_count_q, hit_count_d;
    logic             hit_valid_q, hit_valid_d;
    logic [3:0]       first_hit_q, first_hit_d;

    logic accept;
    logic run;
    logic tick;

    assign accept = (state_q == IDLE) && bus.start;
    assign run    = (state_q == SHIFT);

    tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .run   (run),
        .tick  (tick)
    );

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        idx_d       = idx_q;
        drain_d     = drain_q;
        prev_d      = prev_q;
        hit_count_d = hit_count_q;
        hit_valid_d = hit_valid_q;
        first_hit_d = first_hit_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = SHIFT;
                    word_d      = bus.word;
                    idx_d       = '0;
                    prev_d      = 1'b0;
                    hit_count_d = '0;
                    hit_valid_d = 1'b0;
                    first_hit_d = '0;
                end
            end
            SHIFT: begin
                // The latched word shifts left on every step, so its MSB is
                // always word[WIDTH-1-idx] of the original value.
                if (tick) begin
                    word_d = word_q << 1;
                    idx_d  = idx_q + IW'(1);
                    if (idx_q == IW'(WIDTH - 1)) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end
                end
            end
            DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == 2'(DRAIN_CYC - 1)) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase

        // Hit detection window is SHIFT plus DRAIN; det_out is ignored in
        // IDLE and DONE. Only 0->1 transitions count, so a held level counts once.
        if (state_q == SHIFT || state_q == DRAIN) begin
            prev_d = bus.det_out;
            if (bus.det_out && !prev_q) begin
                if (hit_count_q != 4'hF) hit_count_d = hit_count_q + 4'd1;
                if (!hit_valid_q) begin
                    hit_valid_d = 1'b1;
                    // The match belongs to the bit fed on the previous step.
                    first_hit_d = (idx_q == '0) ? 4'd0 : 4'(idx_q - IW'(1));
                end
            end
        end

        det_rst_d = accept;
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        det_in_d  = (state_d == SHIFT) ? word_d[WIDTH-1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            word_q      <= '0;
            idx_q       <= '0;
            drain_q     <= '0;
            prev_q      <= 1'b0;
            det_rst_q   <= 1'b0;
            det_in_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hit_count_q <= '0;
            hit_valid_q <= 1'b0;
            first_hit_q <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            drain_q     <= drain_d;
            prev_q      <= prev_d;
            det_rst_q   <= det_rst_d;
            det_in_q    <= det_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            hit_count_q <= hit_count_d;
            hit_valid_q <= hit_valid_d;
            first_hit_q <= first_hit_d;
        end
    end

    assign bus.det_rst   = det_rst_q;
    assign bus.det_en    = tick;
    assign bus.det_in    = det_in_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.hit_count = hit_count_q;
    assign bus.hit_valid = hit_valid_q;
    assign bus.first_hit = first_hit_q;
endmodule

// File: tb/tb_pattern_feed_ctrl.sv
// Directed bench for pattern_feed_ctrl (WIDTH=16, DIV=4) with a behavioural
// 101100 detector attached and an override for forcing det_out patterns.
module tb_pattern_feed_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pattern_feed_ctrl_if #(.WIDTH(16)) bus ();

    pattern_feed_ctrl #(.WIDTH(16), .DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Sequence detector for 101100 with a registered match output.
    logic [5:0] hist    = '0;
    logic       det_q   = 1'b0;
    logic       frc_en  = 1'b0;
    logic       frc_val = 1'b0;

    always @(posedge clk) begin
        if (bus.det_rst) begin
            hist  <= '0;
            det_q <= 1'b0;
        end else if (bus.det_en) begin
            hist  <= {hist[4:0], bus.det_in};
            det_q <= ({hist[4:0], bus.det_in} == 6'b101100);
        end
    end

    assign bus.det_out = frc_en ? frc_val : det_q;

    int errs = 0;
    int nchk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Forced det_out value in run cycle i for each override mode.
    function automatic logic frc_at(input int mode, input int i);
        case (mode)
            1:       return ((i >= 2 && i <= 36 && (i % 2) == 0) || (i >= 38 && i <= 77));
            2:       return ((i >= 10 && i <= 30) || i >= 67);
            default: return 1'b0;
        endcase
    endfunction

    int done_at, done_cnt, rst_at, rst2_at, en_cnt, en_bad, both, busy_bad, busy_post;
    int hc, hv, fh;

    // One run: start in cycle T (=0), then observe cycles 1..done+3.
    task automatic run(input logic [15:0] w, input int mode, input int poke, input bit hold);
        done_at = 0; done_cnt = 0; rst_at = 0; rst2_at = 0; en_cnt = 0; en_bad = 0;
        both = 0; busy_bad = 0; busy_post = -1; hc = -1; hv = -1; fh = -1;
        frc_en    = (mode != 0);
        frc_val   = frc_at(mode, 0);
        bus.word  = w;
        bus.start = 1'b1;
        for (int i = 1; i <= 90; i++) begin
            step();
            bus.start = hold || (i == poke);
            frc_val   = frc_at(mode, i);
            if (bus.det_rst === 1'b1) begin
                if (rst_at == 0) rst_at = i;
                else if (rst2_at == 0) rst2_at = i;
            end
            if (bus.det_en === 1'b1) begin
                en_cnt++;
                if (i != en_cnt * 4) en_bad++;
            end
            if (bus.det_en === 1'b1 && bus.det_rst === 1'b1) both++;
            if (done_cnt == 0 && bus.busy !== 1'b1) busy_bad++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = i;
            end
            if (done_at != 0 && i == done_at + 1) begin
                busy_post = bus.busy;
                hc = bus.hit_count;
                hv = bus.hit_valid;
                fh = bus.first_hit;
            end
            if (done_at != 0 && i == done_at + 3) break;
        end
        bus.start = 1'b0;
    endtask

    task automatic chk_run(input string tag, input int e_hc, input int e_hv, input int e_fh, input int e_rst2);
        chk({tag, "_rst_at"},   rst_at,    1);
        chk({tag, "_rst2_at"},  rst2_at,   e_rst2);
        chk({tag, "_en_cnt"},   en_cnt,    16);
        chk({tag, "_en_time"},  en_bad,    0);
        chk({tag, "_done_at"},  done_at,   67);
        chk({tag, "_done_cnt"}, done_cnt,  1);
        chk({tag, "_en_rst"},   both,      0);
        chk({tag, "_busy"},     busy_bad,  0);
        chk({tag, "_busy_end"}, busy_post, 0);
        chk({tag, "_hit_cnt"},  hc,        e_hc);
        chk({tag, "_hit_vld"},  hv,        e_hv);
        chk({tag, "_first"},    fh,        e_fh);
    endtask

    initial begin
        int cnt;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.word  = '0;
        step();
        step();
        chk("reset_outs", {bus.busy, bus.done, bus.det_en, bus.det_rst, bus.det_in,
                           bus.hit_valid, bus.hit_count, bus.first_hit}, 0);
        reset = 1'b0;
        step();

        run(16'hB000, 0, 0, 1'b0);  chk_run("b000", 1, 1, 5, 0);
        run(16'h0000, 0, 0, 1'b0);  chk_run("zero", 0, 0, 0, 0);
        run(16'hB2C0, 0, 0, 1'b0);  chk_run("b2c0", 2, 1, 5, 0);
        run(16'h0000, 1, 0, 1'b0);  chk_run("sat",  15, 1, 0, 0);

        // Held level counts once; det_out high in DONE/IDLE is ignored.
        run(16'h0000, 2, 0, 1'b0);  chk_run("level", 1, 1, 1, 0);
        repeat (5) step();
        chk("idle_ign_cnt", bus.hit_count, 1);
        chk("idle_ign_vld", bus.hit_valid, 1);
        frc_en  = 1'b0;
        frc_val = 1'b0;

        run(16'hB000, 0, 20, 1'b0); chk_run("poke", 1, 1, 5, 0);
        run(16'hB000, 0, 0, 1'b1);  chk_run("hold", 1, 1, 5, 69);

        // Clear the run the held start launched.
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();

        // Reset in the middle of a run.
        bus.word  = 16'hB000;
        bus.start = 1'b1;
        step();                     // cycle 1
        bus.start = 1'b0;
        repeat (28) step();         // cycle 29
        chk("mid_pre_hits", bus.hit_count, 1);
        step();                     // cycle 30
        reset = 1'b1;
        step();                     // cycle 31
        reset = 1'b0;
        chk("mid_rst_outs", {bus.busy, bus.done, bus.det_en, bus.det_rst, bus.det_in,
                             bus.hit_valid, bus.hit_count, bus.first_hit}, 0);
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) cnt++;
        end
        chk("mid_no_done", cnt, 0);

        // Reset wins over start in the same cycle.
        bus.word  = 16'hB000;
        bus.start = 1'b1;
        reset     = 1'b1;
        step();
        reset     = 1'b0;
        bus.start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.busy !== 1'b0 || bus.det_rst !== 1'b0 || bus.det_en !== 1'b0) cnt++;
        end
        chk("rst_start_idle", cnt, 0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
